des_1to32: RTL and testbench
============================

DES_1TO32 -- requirements
Module: des_1to32

Interface
REQ-001 SHALL have parameter: OVR_CNT_W, 8, width of overrun counter (used only with DES_OVR_CNT_EN).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on posedge clk.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: wr_en  input  1  serial bit valid; dataIn sampled when high.
REQ-005 SHALL have port: dataIn  input  1  serial data bit, LSB-first.
REQ-006 SHALL have port: dataOut  output  32  assembled word, held in output register.
REQ-007 SHALL have port: out_valid  output  1  dataOut holds an unconsumed word.
REQ-008 SHALL have port: out_ready  input  1  consumer accepts dataOut when high with out_valid.
REQ-009 SHALL have port: bit_cnt  output  5  index of next bit to be written.
REQ-010 SHALL have port: overrun  output  1  sticky; a completed word was dropped.
REQ-011 SHALL have port: ovr_cnt  output  OVR_CNT_W  dropped-word count (present only with DES_OVR_CNT_EN).

Function
REQ-012 SHALL, on posedge with wr_en=1, write dataIn into shift-register bit [bit_cnt] and increment bit_cnt modulo 32 (31 wraps to 0).
REQ-013 SHALL hold bit_cnt and shift register unchanged when wr_en=0.
REQ-014 SHALL treat wr_en=1 at bit_cnt=31 as word completion; completed word = {dataIn, shreg[30:0]}.
REQ-015 SHALL implement output FSM with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL, on completion in EMPTY, load dataOut and enter FULL; out_valid high in the cycle after the 32nd bit's sampling edge (latency 1).
REQ-017 SHALL, in FULL with out_valid&out_ready and no completion, go to EMPTY; dataOut retains last value.
REQ-018 SHALL, in FULL with completion and out_ready=1 in the same cycle, load the new word and stay FULL (no bubble, no overrun).
REQ-019 SHALL, in FULL with completion and out_ready=0, drop the new word, keep dataOut unchanged, set overrun=1; bit_cnt still wraps to 0.
REQ-020 SHALL keep dataOut stable while out_valid=1 and out_ready=0.
REQ-021 SHALL ignore out_ready in EMPTY.

Reset
REQ-022 SHALL, when rst_n=0 at posedge, clear bit_cnt, shift register, dataOut, out_valid, overrun (and ovr_cnt) to 0 and enter EMPTY.
REQ-023 SHALL discard any partially received word on reset mid-word; reset has priority over wr_en and out_ready.

Configuration
REQ-024 SHALL, with DES_OVR_CNT_EN defined, provide ovr_cnt incrementing by 1 per dropped word, saturating at all-ones.
REQ-025 SHALL, without DES_OVR_CNT_EN, omit ovr_cnt port and counter logic; all other behaviour identical.

Structure
REQ-026 SHALL place WORD_W=32, CNT_W=5 and the EMPTY/FULL state typedef in shared package des_pkg.
REQ-027 SHALL implement the EMPTY/FULL holding register and valid/ready logic as sub-module des_hold_reg.

Verification
REQ-028 SHALL verify: reset, out_ready=1, 32 contiguous bits of 0xA5A50F0F LSB-first -> out_valid=1 one cycle after 32nd bit, dataOut=0xA5A50F0F, bit_cnt=0, overrun=0.
REQ-029 SHALL verify: 0x12345678 with wr_en low gaps of 1-3 cycles -> bit_cnt frozen during gaps, dataOut=0x12345678.
REQ-030 SHALL verify: out_ready=0, words 0x00000001 then 0x00000002 -> dataOut stays 0x00000001, overrun=1 after 64th bit, ovr_cnt=1 (macro on).
REQ-031 SHALL verify: word 0xCAFEF00D completes in the same cycle out_ready=1 accepts 0x11111111 -> out_valid stays 1, dataOut=0xCAFEF00D, overrun=0.
REQ-032 SHALL verify: rst_n=0 after 17 bits -> bit_cnt=0, out_valid=0; next 32 bits of 0xDEADBEEF -> dataOut=0xDEADBEEF.
REQ-033 SHALL verify: macro on, out_ready=0, 300 completed words -> ovr_cnt=255 (OVR_CNT_W=8), no wrap.

Source files
------------

// File: rtl/des_pkg.sv
// Shared definitions for the 1-to-32 deserializer.
//
// Contents:
//   WORD_W       - width of an assembled word (32)
//   CNT_W        - width of the bit index counter (5)
//   hold_state_t - EMPTY/FULL state of the output holding register
package des_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 5;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

endpackage

// File: rtl/des_hold_reg.sv
// Output holding register with valid/ready handshake for des_1to32.
//
// Ports:
//   clk        in   clock, all logic on rising edge
//   rst_n      in   synchronous active-low reset
//   load_en    in   a completed word is presented this cycle
//   load_data  in   the completed word
//   out_ready  in   consumer accepts data_out when out_valid is high
//   data_out   out  held word
//   out_valid  out  data_out holds an unconsumed word
//   drop       out  a completed word is being discarded this cycle
module des_hold_reg
    import des_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_data,
    input  logic              out_ready,
    output logic [WORD_W-1:0] data_out,
    output logic              out_valid,
    output logic              drop
);

    hold_state_t       state_q;
    hold_state_t       state_d;
    logic              capture;
    logic [WORD_W-1:0] data_q;

    // State and data register. The data register only changes on capture,
    // so it stays stable while a word waits for the consumer and keeps its
    // last value after being consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                data_q <= load_data;
            end
        end
    end

    // Next state and capture/drop decisions. A new word arriving while full
    // is accepted only if the consumer takes the old one in the same cycle,
    // which avoids a bubble; otherwise the new word is lost.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (load_en) begin
                    capture = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (load_en) begin
                    if (out_ready) begin
                        capture = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign data_out  = data_q;
    assign out_valid = (state_q == FULL);

endmodule

// File: rtl/des_1to32.sv
// Serial-to-parallel converter: collects 32 serial bits (LSB first) into a
// word and presents it through a valid/ready holding register.
//
// Optional feature: define DES_OVR_CNT_EN to add the saturating ovr_cnt
// output counting dropped words.
//
// Ports:
//   clk        in   clock, all logic on rising edge
//   rst_n      in   synchronous active-low reset
//   wr_en      in   dataIn is valid this cycle
//   dataIn     in   serial data bit
//   dataOut    out  assembled 32-bit word
//   out_valid  out  dataOut holds an unconsumed word
//   out_ready  in   consumer accepts dataOut
//   bit_cnt    out  index of the next bit to be written
//   overrun    out  sticky flag, a completed word was dropped
//   ovr_cnt    out  dropped-word count (DES_OVR_CNT_EN only)
module des_1to32
    import des_pkg::*;
#(
    parameter int OVR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 dataIn,
    output logic [WORD_W-1:0]    dataOut,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_W-1:0]     bit_cnt,
    output logic                 overrun
`ifdef DES_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0] ovr_cnt
`endif
);

    if (OVR_CNT_W < 1) begin : g_bad_ovr_cnt_w
        $error("OVR_CNT_W must be at least 1");
    end

    // Only bits 0..30 need storage; bit 31 is taken straight from dataIn
    // in the completing cycle.
    logic [WORD_W-2:0] shreg;
    logic              complete;
    logic [WORD_W-1:0] word_done;
    logic              drop;

    assign complete  = wr_en && (bit_cnt == CNT_W'(WORD_W - 1));
    assign word_done = {dataIn, shreg};

    // Bit index and shift register. The counter wraps from 31 to 0 through
    // natural 5-bit overflow, including when the completed word is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (wr_en) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            for (int i = 0; i < WORD_W - 1; i++) begin
                if (bit_cnt == CNT_W'(i)) begin
                    shreg[i] <= dataIn;
                end
            end
        end
    end

    des_hold_reg u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en   (complete),
        .load_data (word_done),
        .out_ready (out_ready),
        .data_out  (dataOut),
        .out_valid (out_valid),
        .drop      (drop)
    );

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end
    end

`ifdef DES_OVR_CNT_EN
    // Dropped-word counter that saturates at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else if (drop && (ovr_cnt != '1)) begin
            ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_des_1to32.sv
// Directed self-checking testbench for des_1to32.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_des_1to32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        dataIn;
    logic [31:0] dataOut;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  bit_cnt;
    logic        overrun;
`ifdef DES_OVR_CNT_EN
    logic [7:0]  ovr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_1to32 #(.OVR_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .dataIn    (dataIn),
        .dataOut   (dataOut),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt),
        .overrun   (overrun)
`ifdef DES_OVR_CNT_EN
        ,
        .ovr_cnt   (ovr_cnt)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Sends bits firstBit..lastBit of word, LSB first. With maxGap > 0 a gap
    // of 1..maxGap idle cycles follows each bit except the last, and the bit
    // counter is checked to be frozen throughout the gap.
    task automatic applyStimulus(input logic [31:0] word, input int firstBit,
                                 input int lastBit, input int maxGap);
        for (int i = firstBit; i <= lastBit; i++) begin
            @(negedge clk);
            wr_en  = 1'b1;
            dataIn = word[i];
            if (maxGap > 0 && i < lastBit) begin
                for (int g = 0; g < (i % maxGap) + 1; g++) begin
                    @(negedge clk);
                    wr_en = 1'b0;
                    checkOutput("gap_bit_cnt", 32'(bit_cnt), 32'(i + 1));
                end
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] w;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        dataIn    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        doReset();
        checkOutput("rst_bit_cnt",   32'(bit_cnt),   32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_dataOut",   dataOut,        32'd0);
        checkOutput("rst_overrun",   32'(overrun),   32'd0);
`ifdef DES_OVR_CNT_EN
        checkOutput("rst_ovr_cnt",   32'(ovr_cnt),   32'd0);
`endif

        // Contiguous word, consumer ready, latency of one cycle
        $display("[TB] contiguous word 0xA5A50F0F");
        out_ready = 1'b1;
        applyStimulus(32'hA5A50F0F, 0, 30, 0);
        checkOutput("t1_valid_before", 32'(out_valid), 32'd0);
        checkOutput("t1_bit_cnt_31",   32'(bit_cnt),   32'd31);
        applyStimulus(32'hA5A50F0F, 31, 31, 0);
        checkOutput("t1_valid",   32'(out_valid), 32'd1);
        checkOutput("t1_dataOut", dataOut,        32'hA5A50F0F);
        checkOutput("t1_bit_cnt", 32'(bit_cnt),   32'd0);
        checkOutput("t1_overrun", 32'(overrun),   32'd0);
        @(negedge clk);
        checkOutput("t1_consumed", 32'(out_valid), 32'd0);
        checkOutput("t1_retained", dataOut,        32'hA5A50F0F);

        // Word with idle gaps of 1-3 cycles
        $display("[TB] gapped word 0x12345678");
        applyStimulus(32'h12345678, 0, 31, 3);
        checkOutput("t2_valid",   32'(out_valid), 32'd1);
        checkOutput("t2_dataOut", dataOut,        32'h12345678);
        checkOutput("t2_bit_cnt", 32'(bit_cnt),   32'd0);

        // Overrun with consumer stalled
        $display("[TB] overrun with out_ready low");
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus(32'h00000001, 0, 31, 0);
        checkOutput("t3_valid1",   32'(out_valid), 32'd1);
        checkOutput("t3_data1",    dataOut,        32'h00000001);
        checkOutput("t3_overrun0", 32'(overrun),   32'd0);
        repeat (3) @(negedge clk);
        checkOutput("t3_stable",   dataOut,        32'h00000001);
        applyStimulus(32'h00000002, 0, 31, 0);
        checkOutput("t3_data2",    dataOut,        32'h00000001);
        checkOutput("t3_overrun1", 32'(overrun),   32'd1);
        checkOutput("t3_valid2",   32'(out_valid), 32'd1);
        checkOutput("t3_bit_cnt",  32'(bit_cnt),   32'd0);
`ifdef DES_OVR_CNT_EN
        checkOutput("t3_ovr_cnt",  32'(ovr_cnt),   32'd1);
`endif

        // Completion coinciding with acceptance of the held word
        $display("[TB] back-to-back completion and accept");
        doReset();
        out_ready = 1'b0;
        applyStimulus(32'h11111111, 0, 31, 0);
        checkOutput("t4_held", dataOut, 32'h11111111);
        w = 32'hCAFEF00D;
        applyStimulus(w, 0, 30, 0);
        @(negedge clk);
        wr_en     = 1'b1;
        dataIn    = w[31];
        out_ready = 1'b1;
        @(negedge clk);
        wr_en     = 1'b0;
        out_ready = 1'b0;
        checkOutput("t4_valid",   32'(out_valid), 32'd1);
        checkOutput("t4_dataOut", dataOut,        32'hCAFEF00D);
        checkOutput("t4_overrun", 32'(overrun),   32'd0);

        // Reset in the middle of a word, with wr_en and out_ready high
        $display("[TB] reset after 17 bits");
        applyStimulus(32'hFFFFFFFF, 0, 16, 0);
        checkOutput("t5_bit_cnt17", 32'(bit_cnt),   32'd17);
        checkOutput("t5_full",      32'(out_valid), 32'd1);
        @(negedge clk);
        rst_n     = 1'b0;
        wr_en     = 1'b1;
        dataIn    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_bit_cnt", 32'(bit_cnt),   32'd0);
        checkOutput("t5_rst_valid",   32'(out_valid), 32'd0);
        checkOutput("t5_rst_dataOut", dataOut,        32'd0);
        rst_n     = 1'b1;
        wr_en     = 1'b0;
        out_ready = 1'b0;
        applyStimulus(32'hDEADBEEF, 0, 31, 0);
        checkOutput("t5_dataOut", dataOut,        32'hDEADBEEF);
        checkOutput("t5_valid",   32'(out_valid), 32'd1);

        // Long stall: one word held, 299 dropped
        $display("[TB] 300 words with out_ready low");
        doReset();
        out_ready = 1'b0;
        for (int n = 0; n < 300; n++) begin
            w = (n == 0) ? 32'h0BADF00D : 32'(n);
            applyStimulus(w, 0, 31, 0);
        end
        checkOutput("t6_dataOut", dataOut,      32'h0BADF00D);
        checkOutput("t6_overrun", 32'(overrun), 32'd1);
        checkOutput("t6_bit_cnt", 32'(bit_cnt), 32'd0);
`ifdef DES_OVR_CNT_EN
        checkOutput("t6_ovr_cnt", 32'(ovr_cnt), 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
